// File: rtl/tmds_encoder_ctrl.sv
// TMDS channel encoder: stage-1 transition minimisation plus DVI stage-2 DC balancing
// with a registered running-disparity counter and control-token insertion during blanking.

module tmds_stage_1 (
  input  logic [7:0] d_i,
  input  logic       invert_i,
  output logic [8:0] q_m_o
);

  logic [7:0] acc_s;

  // XOR (or XNOR when inverting) chain, each bit built from the previous output bit
  always_comb begin
    acc_s    = 8'b0;
    acc_s[0] = d_i[0];
    for (int i = 1; i < 8; i++) begin
      if (invert_i) begin
        acc_s[i] = ~(acc_s[i-1] ^ d_i[i]);
      end else begin
        acc_s[i] = acc_s[i-1] ^ d_i[i];
      end
    end
    q_m_o = {~invert_i, acc_s};
  end

endmodule

module tmds_encoder_ctrl (
  input  logic       clk,
  input  logic       rst,
  input  logic       ce,
  input  logic       de,
  input  logic [1:0] c,
  input  logic [7:0] D,
  output logic [9:0] dout,
  output logic [4:0] disparity
);

  localparam logic [9:0] TOKEN_00 = 10'b1101010100;
  localparam logic [9:0] TOKEN_01 = 10'b0010101011;
  localparam logic [9:0] TOKEN_10 = 10'b0101010100;
  localparam logic [9:0] TOKEN_11 = 10'b1010101011;

  function automatic logic [3:0] popcount8(input logic [7:0] v);
    logic [3:0] n;
    n = 4'd0;
    for (int i = 0; i < 8; i++) begin
      n = n + {3'd0, v[i]};
    end
    return n;
  endfunction

  // Stage A registers
  logic [7:0] d_a_q,   d_a_d;
  logic       de_a_q,  de_a_d;
  logic [1:0] c_a_q,   c_a_d;
  logic       inv_a_q, inv_a_d;

  // Stage B registers
  logic [9:0]        dout_q, dout_d;
  logic signed [4:0] cnt_q,  cnt_d;

  logic [3:0]        n1_s;
  logic              inv_s;
  logic [8:0]        q_m_s;
  logic [3:0]        n1_qm_s;
  logic signed [5:0] diff_s;
  logic signed [5:0] cnt_ext_s;
  logic signed [5:0] qm8_x2_s;
  logic signed [5:0] nqm8_x2_s;
  logic signed [5:0] cnt_sum_s;
  logic              cnt_zero_s;
  logic              cnt_pos_s;
  logic              cnt_neg_s;
  logic              use_r0_s;
  logic              use_r1_s;

  // Stage A next state: capture pixel inputs and decide the stage-1 invert control
  always_comb begin
    n1_s  = popcount8(D);
    inv_s = (n1_s > 4'd4) || ((n1_s == 4'd4) && !D[0]);
    if (ce) begin
      d_a_d   = D;
      de_a_d  = de;
      c_a_d   = c;
      inv_a_d = inv_s;
    end else begin
      d_a_d   = d_a_q;
      de_a_d  = de_a_q;
      c_a_d   = c_a_q;
      inv_a_d = inv_a_q;
    end
  end

  tmds_stage_1 u_stage_1 (
    .d_i      (d_a_q),
    .invert_i (inv_a_q),
    .q_m_o    (q_m_s)
  );

  // Disparity terms, all carried at 6 bits; diff_s = N1 - N0 = 2*N1 - 8
  always_comb begin
    n1_qm_s    = popcount8(q_m_s[7:0]);
    diff_s     = $signed({1'b0, n1_qm_s, 1'b0}) - 6'sd8;
    cnt_ext_s  = {cnt_q[4], cnt_q};
    qm8_x2_s   = $signed({4'd0, q_m_s[8], 1'b0});
    nqm8_x2_s  = $signed({4'd0, ~q_m_s[8], 1'b0});
    cnt_zero_s = (cnt_q == 5'sd0);
    cnt_neg_s  = cnt_q[4];
    cnt_pos_s  = !cnt_q[4] && !cnt_zero_s;
    use_r0_s   = cnt_zero_s || (n1_qm_s == 4'd4);
    use_r1_s   = (cnt_pos_s && (n1_qm_s > 4'd4)) || (cnt_neg_s && (n1_qm_s < 4'd4));
  end

  // Stage B next state: balance rule selection or control token, gated by ce
  always_comb begin
    dout_d    = dout_q;
    cnt_d     = cnt_q;
    cnt_sum_s = cnt_ext_s;
    if (ce) begin
      if (!de_a_q) begin
        cnt_d = 5'sd0;
        case (c_a_q)
          2'b00:   dout_d = TOKEN_00;
          2'b01:   dout_d = TOKEN_01;
          2'b10:   dout_d = TOKEN_10;
          2'b11:   dout_d = TOKEN_11;
          default: dout_d = TOKEN_00;
        endcase
      end else if (use_r0_s) begin
        dout_d = {~q_m_s[8], q_m_s[8], (q_m_s[8] ? q_m_s[7:0] : ~q_m_s[7:0])};
        if (q_m_s[8]) begin
          cnt_sum_s = cnt_ext_s + diff_s;
        end else begin
          cnt_sum_s = cnt_ext_s - diff_s;
        end
        cnt_d = cnt_sum_s[4:0];
      end else if (use_r1_s) begin
        dout_d    = {1'b1, q_m_s[8], ~q_m_s[7:0]};
        cnt_sum_s = cnt_ext_s + qm8_x2_s - diff_s;
        cnt_d     = cnt_sum_s[4:0];
      end else begin
        dout_d    = {1'b0, q_m_s[8], q_m_s[7:0]};
        cnt_sum_s = cnt_ext_s + diff_s - nqm8_x2_s;
        cnt_d     = cnt_sum_s[4:0];
      end
    end else begin
      dout_d = dout_q;
      cnt_d  = cnt_q;
    end
  end

  // Pipeline registers; reset wins over ce
  always_ff @(posedge clk) begin
    if (rst) begin
      d_a_q   <= 8'd0;
      de_a_q  <= 1'b0;
      c_a_q   <= 2'b00;
      inv_a_q <= 1'b0;
      dout_q  <= TOKEN_00;
      cnt_q   <= 5'sd0;
    end else begin
      d_a_q   <= d_a_d;
      de_a_q  <= de_a_d;
      c_a_q   <= c_a_d;
      inv_a_q <= inv_a_d;
      dout_q  <= dout_d;
      cnt_q   <= cnt_d;
    end
  end

  assign dout      = dout_q;
  assign disparity = cnt_q;

endmodule

// File: doc/tmds_encoder_ctrl.md
# tmds_encoder_ctrl

Sequencing and DC-balance controller for one TMDS channel. It drives `tmds_stage_1` by choosing the `invert` control per pixel from the data popcount. It then applies DVI 1.0 stage-2 DC balancing to `q_m`, using a registered running-disparity counter, and inserts control tokens during blanking. One instance sits per colour channel, between the video timing generator and the 10:1 serializer, in the pixel-clock domain.

## Interface
Parameters: none.

Ports:
- clk  in  1  pixel clock; all logic is on the rising edge.
- rst  in  1  reset. Synchronous, active-high.
- ce  in  1  pixel clock-enable. When low, every register holds.
- de  in  1  data enable. 1 = active video, 0 = blanking.
- c  in  2  control bits (HSYNC/VSYNC on channel 0). Used only when de=0.
- D  in  8  pixel data byte. Used only when de=1.
- dout  out  10  encoded TMDS symbol. Bit 0 is transmitted first.
- disparity  out  5  running disparity `cnt`, signed two's complement, for debug and observability.

## Operation
- **Stage A (registered when ce=1):**
  - Captures D_a, de_a and c_a.
  - Computes n1 = popcount(D). Width 4; range 0..8.
  - Computes inv_a = (n1>4) || (n1==4 && D[0]==0).
- **Stage B (combinational plus output register):**
  - `tmds_stage_1` is instantiated with D=D_a and invert=inv_a, producing q_m[8:0]. Note: q_m[8] = ~inv_a.
  - N1 = popcount(q_m[7:0]) and N0 = 8-N1. The difference is held as a 5-bit signed value.
- **Balance rules, applied when de_a=1.** Exactly one rule applies per symbol.
  - **R0:** if cnt==0 or N1==N0:
    - dout = {~q_m[8], q_m[8], q_m[8] ? q_m[7:0] : ~q_m[7:0]}.
    - cnt += q_m[8] ? (N1-N0) : (N0-N1).
  - **R1:** else if (cnt>0 && N1>N0) or (cnt<0 && N0>N1):
    - dout = {1, q_m[8], ~q_m[7:0]}.
    - cnt += 2*q_m[8] + (N0-N1).
  - **R2:** otherwise:
    - dout = {0, q_m[8], q_m[7:0]}.
    - cnt += (N1-N0) - 2*(~q_m[8]).
- **Blanking (de_a=0):** cnt is set to 0 and dout is a control token selected by c_a:
  - 00 → 10'b1101010100
  - 01 → 10'b0010101011
  - 10 → 10'b0101010100
  - 11 → 10'b1010101011
- **Arithmetic:**
  - cnt is 5-bit signed and always even; its magnitude never exceeds 10.
  - All additions are done at 6 bits and then truncated. A correct design never relies on wrap.
- disparity = cnt.

## Timing
- **Reset values** (on the rst cycle, regardless of ce):
  - dout = 10'b1101010100 (the c=00 token).
  - disparity = 0.
  - de_a = 0, c_a = 00, D_a = 0.
- **Latency:** 2 ce-qualified edges from input to dout. An input sampled at edge k (ce=1) appears on dout after edge k+1 with ce=1.
- cnt is updated on the same edge that registers the dout it produced, so disparity reflects the symbol currently on dout.
- **ce=0:** dout, cnt and stage A hold. There is no bubble and no duplicate; the sequence resumes exactly where it stopped.
- **de transitions:**
  - On the first blanking symbol, cnt is forced to 0. The first active symbol after blanking therefore always uses R0.
  - Blanking→active and active→blanking switch on the symbol boundary. There is no extra latency.
- **rst mid-line:** rst takes priority over ce and clears the pipeline. The next two dout values are control tokens (de_a was cleared), even if de=1 is presented immediately.

## Test plan
- **Reset, then 0x00 run.** rst for 2 cycles, then de=1, D=0x00 ×3 with ce=1.
  - While in reset: dout=0x354, disparity=0.
  - Then: dout=0x100 (cnt -8), 0x3FF (cnt +2), 0x100 (cnt -6).
- **Single 0xFF after blanking.** de=0 then de=1, D=0xFF.
  - inv=1, q_m=0x0FF.
  - dout=0x200, disparity=-8.
- **Control tokens.** de=0, c = 00/01/10/11.
  - dout = 0x354 / 0x0AB / 0x154 / 0x2AB, each 2 cycles after its input.
  - disparity = 0 throughout.
- **ce stall.** Repeat the 0x00 run with ce toggling 1,0,0,1,…
  - Same dout sequence 0x100, 0x3FF, 0x100, each value held while ce=0.
  - No symbol skipped or repeated.
- **Reset mid-line.** rst for 1 cycle during an active 0x00 run.
  - dout = 0x354 for the next 2 ce edges.
  - Afterwards the encoding restarts from cnt=0 (first symbol 0x100).
- **Random soak.** 100k random D/de/c/ce values, checked against a behavioural model.
  - dout matches bit-exact.
  - cnt is always even and |cnt| ≤ 10.
  - Decoding dout recovers D, and recovers c during blanking.
